// File: rtl/aes_bus_pkg.sv
// Shared definitions for the aes register-block bus master: register map,
// bit positions inside ctrl/status/config, and the controller state set.
package aes_bus_pkg;

    localparam logic [7:0] ADDR_CTRL    = 8'h08;
    localparam logic [7:0] ADDR_STATUS  = 8'h09;
    localparam logic [7:0] ADDR_CONFIG  = 8'h0a;
    localparam logic [7:0] ADDR_KEY0    = 8'h10;
    localparam logic [7:0] ADDR_BLOCK0  = 8'h20;
    localparam logic [7:0] ADDR_RESULT0 = 8'h30;

    localparam int CTRL_INIT_BIT     = 0;
    localparam int CTRL_NEXT_BIT     = 1;
    localparam int STATUS_READY_BIT  = 0;
    localparam int STATUS_VALID_BIT  = 1;
    localparam int CONFIG_ENCDEC_BIT = 0;

    localparam int WORD_SEL_W = 2;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_KEY_WR,
        ST_CFG_WR,
        ST_INIT_WR,
        ST_BLK_WR,
        ST_NEXT_WR,
        ST_GUARD,
        ST_POLL,
        ST_RES_RD,
        ST_OUT
    } aes_state_e;

    // Word 0 is the most significant 32 bits of a 128-bit value.
    function automatic logic [31:0] word_of(input logic [127:0] v,
                                            input logic [WORD_SEL_W-1:0] sel);
        logic [31:0] w;
        w = v[127:96];
        case (sel)
            2'd1:    w = v[95:64];
            2'd2:    w = v[63:32];
            2'd3:    w = v[31:0];
            default: w = v[127:96];
        endcase
        return w;
    endfunction

endpackage

// File: rtl/aes_stream_ctrl.sv
// Stream front end for the aes register block: loads keys, pushes one block
// at a time through the write/next/poll/read sequence and streams results.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for a key or block transfer
// KEY_WR   | writing key words 0..3 to 0x10..0x13
// CFG_WR   | writing encdec to config
// INIT_WR  | one-cycle init pulse on ctrl
// BLK_WR   | writing block words 0..3 to 0x20..0x23
// NEXT_WR  | one-cycle next pulse on ctrl
// GUARD    | bus idle while the status register catches up
// POLL     | reading status every cycle, bounded by TIMEOUT
// RES_RD   | reading result words 0..3 into out_block
// OUT      | presenting out_block until out_ready
module aes_stream_ctrl
    import aes_bus_pkg::*;
#(
    parameter int POLL_GUARD = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [127:0] key,
    input  logic         key_encdec,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_block,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_block,
    output logic         busy,
    output logic         error,
    output logic         aes_cs,
    output logic         aes_we,
    output logic [7:0]   aes_address,
    output logic [31:0]  aes_write_data,
    input  logic [31:0]  aes_read_data
);

    localparam int CNT_MAX  = (TIMEOUT > POLL_GUARD) ? TIMEOUT : POLL_GUARD;
    localparam int CNT_BITS = $clog2(CNT_MAX + 1);
    localparam int CNT_W    = (CNT_BITS > 8) ? CNT_BITS : 8;
    localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'((POLL_GUARD > 0) ? POLL_GUARD - 1 : 0);
    localparam logic [CNT_W-1:0] POLL_LAST  = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam aes_state_e AFTER_CTRL = (POLL_GUARD > 0) ? ST_GUARD : ST_POLL;

    aes_state_e                state_q, state_d;
    logic [WORD_SEL_W-1:0]     word_cnt_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [127:0]              key_q;
    logic [127:0]              blk_q;
    logic [127:0]              out_block_q;
    logic                      encdec_q;
    logic                      key_loaded_q;
    logic                      blk_path_q;
    logic                      error_q;
    logic                      run_q;

    logic key_xfer, in_xfer;
    logic key_done, poll_timeout;
    logic status_ready, status_valid;

    // run_q keeps the handshake readies low while reset is asserted.
    assign key_ready = (state_q == ST_IDLE) & run_q;
    assign in_ready  = key_ready & key_loaded_q & ~key_valid;
    assign key_xfer  = key_valid & key_ready;
    assign in_xfer   = in_valid & in_ready;
    assign out_valid = (state_q == ST_OUT);
    assign out_block = out_block_q;
    assign busy      = (state_q != ST_IDLE);
    assign error     = error_q;

    assign status_ready = aes_read_data[STATUS_READY_BIT];
    assign status_valid = aes_read_data[STATUS_VALID_BIT];

    always_comb begin
        state_d        = state_q;
        aes_cs         = 1'b0;
        aes_we         = 1'b0;
        aes_address    = 8'h00;
        aes_write_data = 32'h0;
        key_done       = 1'b0;
        poll_timeout   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (key_xfer) begin
                    state_d = ST_KEY_WR;
                end else if (in_xfer) begin
                    state_d = ST_BLK_WR;
                end
            end
            ST_KEY_WR: begin
                aes_cs         = 1'b1;
                aes_we         = 1'b1;
                aes_address    = ADDR_KEY0 | {6'd0, word_cnt_q};
                aes_write_data = word_of(key_q, word_cnt_q);
                if (word_cnt_q == 2'd3) state_d = ST_CFG_WR;
            end
            ST_CFG_WR: begin
                aes_cs      = 1'b1;
                aes_we      = 1'b1;
                aes_address = ADDR_CONFIG;
                aes_write_data[CONFIG_ENCDEC_BIT] = encdec_q;
                state_d     = ST_INIT_WR;
            end
            ST_INIT_WR: begin
                aes_cs      = 1'b1;
                aes_we      = 1'b1;
                aes_address = ADDR_CTRL;
                aes_write_data[CTRL_INIT_BIT] = 1'b1;
                state_d     = AFTER_CTRL;
            end
            ST_BLK_WR: begin
                aes_cs         = 1'b1;
                aes_we         = 1'b1;
                aes_address    = ADDR_BLOCK0 | {6'd0, word_cnt_q};
                aes_write_data = word_of(blk_q, word_cnt_q);
                if (word_cnt_q == 2'd3) state_d = ST_NEXT_WR;
            end
            ST_NEXT_WR: begin
                aes_cs      = 1'b1;
                aes_we      = 1'b1;
                aes_address = ADDR_CTRL;
                aes_write_data[CTRL_NEXT_BIT] = 1'b1;
                state_d     = AFTER_CTRL;
            end
            ST_GUARD: begin
                if (cnt_q == '0) state_d = ST_POLL;
            end
            ST_POLL: begin
                aes_cs      = 1'b1;
                aes_address = ADDR_STATUS;
                if (blk_path_q && status_ready && status_valid) begin
                    state_d = ST_RES_RD;
                end else if (!blk_path_q && status_ready) begin
                    key_done = 1'b1;
                    state_d  = ST_IDLE;
                end else if (cnt_q == POLL_LAST) begin
                    poll_timeout = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            ST_RES_RD: begin
                aes_cs      = 1'b1;
                aes_address = ADDR_RESULT0 | {6'd0, word_cnt_q};
                if (word_cnt_q == 2'd3) state_d = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            word_cnt_q   <= '0;
            cnt_q        <= '0;
            key_q        <= '0;
            blk_q        <= '0;
            out_block_q  <= '0;
            encdec_q     <= 1'b0;
            key_loaded_q <= 1'b0;
            blk_path_q   <= 1'b0;
            error_q      <= 1'b0;
            run_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;

            if (state_d != state_q) begin
                word_cnt_q <= '0;
            end else if (state_q inside {ST_KEY_WR, ST_BLK_WR, ST_RES_RD}) begin
                word_cnt_q <= word_cnt_q + 1'b1;
            end

            // Guard counts down to a terminal zero; poll counts up from zero.
            if (state_d != state_q) begin
                cnt_q <= (state_d == ST_GUARD) ? GUARD_LOAD : '0;
            end else if (state_q == ST_GUARD) begin
                cnt_q <= cnt_q - 1'b1;
            end else if (state_q == ST_POLL) begin
                cnt_q <= cnt_q + 1'b1;
            end

            if (key_xfer) begin
                key_q        <= key;
                encdec_q     <= key_encdec;
                error_q      <= 1'b0;
                key_loaded_q <= 1'b0;
                blk_path_q   <= 1'b0;
            end
            if (in_xfer) begin
                blk_q      <= in_block;
                blk_path_q <= 1'b1;
            end
            if (key_done) key_loaded_q <= 1'b1;
            if (poll_timeout) begin
                error_q      <= 1'b1;
                key_loaded_q <= 1'b0;
            end

            if (state_q == ST_RES_RD) begin
                case (word_cnt_q)
                    2'd0:    out_block_q[127:96] <= aes_read_data;
                    2'd1:    out_block_q[95:64]  <= aes_read_data;
                    2'd2:    out_block_q[63:32]  <= aes_read_data;
                    default: out_block_q[31:0]   <= aes_read_data;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_aes_stream_ctrl.sv
// Directed bench for aes_stream_ctrl against a behavioural aes register stub
// and a transaction-level model of the expected result stream.
module tb_aes_stream_ctrl;

    localparam int CORE_LAT = 12;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         reset;
    logic         key_valid, key_ready, key_encdec;
    logic [127:0] key;
    logic         in_valid, in_ready;
    logic [127:0] in_block;
    logic         out_valid, out_ready;
    logic [127:0] out_block;
    logic         busy, error;
    logic         aes_cs, aes_we;
    logic [7:0]   aes_address;
    logic [31:0]  aes_write_data, aes_read_data;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    aes_stream_ctrl dut (
        .clk(clk), .reset(reset),
        .key_valid(key_valid), .key_ready(key_ready), .key(key), .key_encdec(key_encdec),
        .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block),
        .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block),
        .busy(busy), .error(error),
        .aes_cs(aes_cs), .aes_we(aes_we), .aes_address(aes_address),
        .aes_write_data(aes_write_data), .aes_read_data(aes_read_data)
    );

    // Cipher stand-in: the FIPS-197 pair is exact, anything else is a keyed xor.
    function automatic logic [127:0] aes_fn(input logic [127:0] k, input logic ed,
                                            input logic [127:0] b);
        if (k == FIPS_KEY && ed && b == FIPS_PT) return FIPS_CT;
        if (k == FIPS_KEY && !ed && b == FIPS_CT) return FIPS_PT;
        return b ^ k ^ {128{ed}};
    endfunction

    task automatic chk_b(input string name, input logic act, input logic exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic chk_w(input string name, input logic [127:0] act, input logic [127:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // ---------------- aes register stub ----------------
    logic [127:0] s_key, s_blk, s_res;
    logic         s_ed, s_ready, s_valid, s_next;
    int           s_cnt;
    logic         stuck = 1'b0;
    int           status_reads = 0;
    logic [39:0]  wr_trace[$];

    always @(posedge clk) begin
        if (reset) begin
            s_key <= '0; s_blk <= '0; s_res <= '0; s_ed <= 1'b0;
            s_ready <= 1'b1; s_valid <= 1'b0; s_next <= 1'b0; s_cnt <= 0;
            status_reads = 0;
        end else begin
            if (s_cnt > 0) begin
                s_cnt <= s_cnt - 1;
                if (s_cnt == 1) begin
                    s_ready <= 1'b1;
                    if (s_next) begin
                        s_valid <= 1'b1;
                        s_res   <= aes_fn(s_key, s_ed, s_blk);
                    end
                end
            end
            if (aes_cs && aes_we) begin
                wr_trace.push_back({aes_address, aes_write_data});
                if (aes_address[7:2] == 6'h04 || aes_address[7:2] == 6'h08) begin
                    case (aes_address[1:0])
                        2'd0: if (aes_address[5]) s_blk[127:96] <= aes_write_data; else s_key[127:96] <= aes_write_data;
                        2'd1: if (aes_address[5]) s_blk[95:64]  <= aes_write_data; else s_key[95:64]  <= aes_write_data;
                        2'd2: if (aes_address[5]) s_blk[63:32]  <= aes_write_data; else s_key[63:32]  <= aes_write_data;
                        default: if (aes_address[5]) s_blk[31:0] <= aes_write_data; else s_key[31:0] <= aes_write_data;
                    endcase
                end else if (aes_address == 8'h0a) begin
                    s_ed <= aes_write_data[0];
                end else if (aes_address == 8'h08) begin
                    status_reads = 0;
                    if (aes_write_data[0] || aes_write_data[1]) begin
                        s_ready <= 1'b0;
                        s_next  <= aes_write_data[1];
                        if (aes_write_data[1]) s_valid <= 1'b0;
                        s_cnt   <= stuck ? 0 : CORE_LAT;
                    end
                end
            end
            if (aes_cs && !aes_we && aes_address == 8'h09) status_reads++;
        end
    end

    always_comb begin
        aes_read_data = 32'h0;
        if (aes_address == 8'h09) begin
            aes_read_data = {30'd0, s_valid, s_ready};
        end else if (aes_address[7:2] == 6'h0c) begin
            case (aes_address[1:0])
                2'd0:    aes_read_data = s_res[127:96];
                2'd1:    aes_read_data = s_res[95:64];
                2'd2:    aes_read_data = s_res[63:32];
                default: aes_read_data = s_res[31:0];
            endcase
        end
    end

    // ---------------- stream model and per-cycle compare ----------------
    logic [127:0] exp_q[$];
    logic [127:0] m_key = '0;
    logic         m_ed = 1'b0;
    logic         prev_hold = 1'b0;
    logic [127:0] prev_block = '0;

    always begin
        @(negedge clk);
        #2;
        if (reset) begin
            exp_q.delete();
            prev_hold = 1'b0;
        end else begin
            if (!aes_we) chk_w("wdata_zero_when_read", {96'd0, aes_write_data}, 128'd0);
            if (aes_we)  chk_b("we_implies_cs", aes_cs, 1'b1);
            if (in_ready) chk_b("in_ready_only_without_key", key_valid, 1'b0);
            if (key_ready) chk_b("key_ready_only_idle", busy, 1'b0);
            if (prev_hold) begin
                chk_b("hold_out_valid", out_valid, 1'b1);
                chk_w("hold_out_block", out_block, prev_block);
            end
            if (key_valid && key_ready) begin
                m_key = key;
                m_ed  = key_encdec;
            end
            if (in_valid && in_ready) exp_q.push_back(aes_fn(m_key, m_ed, in_block));
            if (out_valid && out_ready) begin
                chk_b("out_has_model_entry", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) chk_w("model_out_block", out_block, exp_q.pop_front());
            end
            prev_hold  = out_valid && !out_ready;
            prev_block = out_block;
        end
    end

    // ---------------- drivers ----------------
    task automatic send_key(input logic [127:0] k, input logic ed);
        bit got = 1'b0;
        @(negedge clk);
        key = k; key_encdec = ed; key_valid = 1'b1;
        for (int i = 0; i < 2000 && !got; i++) begin
            #2;
            if (key_ready) begin got = 1'b1; @(posedge clk); end
            else @(negedge clk);
        end
        #1 key_valid = 1'b0;
        chk_b("key_accepted", got, 1'b1);
    endtask

    task automatic send_block(input logic [127:0] b);
        bit got = 1'b0;
        @(negedge clk);
        in_block = b; in_valid = 1'b1;
        for (int i = 0; i < 2000 && !got; i++) begin
            #2;
            if (in_ready) begin got = 1'b1; @(posedge clk); end
            else @(negedge clk);
        end
        #1 in_valid = 1'b0;
        chk_b("block_accepted", got, 1'b1);
    endtask

    task automatic get_out(input string name, input logic [127:0] exp);
        bit got = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 2000 && !got; i++) begin
            #2;
            if (out_valid) begin
                got = 1'b1;
                chk_w(name, out_block, exp);
                @(posedge clk);
            end else @(negedge clk);
        end
        #1 out_ready = 1'b0;
        chk_b("result_delivered", got, 1'b1);
    endtask

    logic [39:0] exp_tr[6];
    bit          seen;

    initial begin
        exp_tr = '{40'h10_00010203, 40'h11_04050607, 40'h12_08090a0b,
                   40'h13_0c0d0e0f, 40'h0a_00000001, 40'h08_00000001};
        reset = 1'b1; key_valid = 1'b0; key_encdec = 1'b0; key = '0;
        in_valid = 1'b0; in_block = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        chk_b("rst_key_ready", key_ready, 1'b0);
        chk_b("rst_in_ready", in_ready, 1'b0);
        chk_b("rst_out_valid", out_valid, 1'b0);
        chk_b("rst_busy", busy, 1'b0);
        chk_b("rst_error", error, 1'b0);
        chk_b("rst_aes_cs", aes_cs, 1'b0);
        chk_w("rst_out_block", out_block, 128'd0);
        @(negedge clk) reset = 1'b0;

        // Block offered before any key: never accepted.
        wr_trace.delete();
        in_block = FIPS_PT; in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk); #2;
            chk_b("no_key_in_ready", in_ready, 1'b0);
        end
        // Key and block together: key wins.
        @(negedge clk);
        key = FIPS_KEY; key_encdec = 1'b1; key_valid = 1'b1;
        #2;
        chk_b("both_key_ready", key_ready, 1'b1);
        chk_b("both_in_blocked", in_ready, 1'b0);
        @(posedge clk);
        #1 key_valid = 1'b0;
        send_block(FIPS_PT);
        chk_i("key_trace_len", wr_trace.size(), 6);
        for (int i = 0; i < 6 && i < wr_trace.size(); i++)
            chk_w("key_trace_entry", {88'd0, wr_trace[i]}, {88'd0, exp_tr[i]});
        get_out("fips_encrypt", FIPS_CT);

        // FIPS-197 decrypt.
        send_key(FIPS_KEY, 1'b0);
        send_block(FIPS_CT);
        get_out("fips_decrypt", FIPS_PT);

        // Backpressure with a follow-up block waiting.
        send_key(FIPS_KEY, 1'b1);
        send_block(FIPS_PT);
        seen = 1'b0;
        for (int i = 0; i < 500 && !seen; i++) begin
            @(negedge clk); #2;
            seen = out_valid;
        end
        chk_b("bp_out_valid_seen", seen, 1'b1);
        in_block = 128'hffeeddccbbaa99887766554433221100; in_valid = 1'b1;
        repeat (20) begin
            @(negedge clk); #2;
            chk_b("bp_out_valid", out_valid, 1'b1);
            chk_w("bp_out_block", out_block, FIPS_CT);
            chk_b("bp_in_ready", in_ready, 1'b0);
            chk_b("bp_no_bus", aes_cs, 1'b0);
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        @(negedge clk); #2;
        chk_b("in_ready_after_out", in_ready, 1'b1);
        @(posedge clk); #1 in_valid = 1'b0;
        get_out("xor_pattern", 128'h00102030405060708090a0b0c0d0e0f0);

        // Status stuck at 0: poll timeout.
        stuck = 1'b1;
        send_key(FIPS_KEY, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            @(negedge clk); #2;
            seen = error;
        end
        chk_b("timeout_error", error, 1'b1);
        chk_i("timeout_poll_count", status_reads, 255);
        chk_b("timeout_idle", busy, 1'b0);
        in_block = FIPS_PT; in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk); #2;
            chk_b("timeout_in_ready", in_ready, 1'b0);
        end
        in_valid = 1'b0;
        stuck = 1'b0;
        send_key(FIPS_KEY, 1'b1);
        @(negedge clk); #2;
        chk_b("key_clears_error", error, 1'b0);
        send_block(FIPS_PT);
        get_out("encrypt_after_timeout", FIPS_CT);

        // Reset while polling.
        send_block(FIPS_PT);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk); #2;
            seen = aes_cs && !aes_we && aes_address == 8'h09;
        end
        chk_b("reached_poll", seen, 1'b1);
        @(negedge clk) reset = 1'b1;
        @(negedge clk); #2;
        chk_b("mid_rst_out_valid", out_valid, 1'b0);
        chk_b("mid_rst_busy", busy, 1'b0);
        chk_b("mid_rst_key_ready", key_ready, 1'b0);
        chk_b("mid_rst_in_ready", in_ready, 1'b0);
        chk_b("mid_rst_aes_cs", aes_cs, 1'b0);
        chk_b("mid_rst_aes_we", aes_we, 1'b0);
        chk_w("mid_rst_bus", {88'd0, aes_address, aes_write_data}, 128'd0);
        chk_w("mid_rst_out_block", out_block, 128'd0);
        @(negedge clk) reset = 1'b0;
        send_key(FIPS_KEY, 1'b1);
        send_block(FIPS_PT);
        get_out("encrypt_after_reset", FIPS_CT);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", pass_cnt, total_cnt);
        $fatal(1);
    end

endmodule
